// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: state encoding,
// datapath width and reset/default constants.
package fetch_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  localparam int unsigned INSTR_W          = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer holding (instruction, PC) pairs.
// Flush wins over push and pop; a push with a pop at any occupancy does both.
module fetch_fifo
  import fetch_ctrl_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               push_i,
  input  logic [INSTR_W-1:0] push_data_i,
  input  logic [31:0]        push_pc_i,
  input  logic               pop_i,
  output logic [INSTR_W-1:0] head_data_o,
  output logic [31:0]        head_pc_o,
  output logic [1:0]         count_o
);

  logic [INSTR_W-1:0] data_q [2];
  logic [31:0]        pc_q   [2];
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_i) wr_ptr_d = ~wr_ptr_q;
      if (pop_i)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: the count alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) begin
      data_q[wr_ptr_q] <= push_data_i;
      pc_q[wr_ptr_q]   <= push_pc_i;
    end
  end

  assign head_data_o = data_q[rd_ptr_q];
  assign head_pc_o   = pc_q[rd_ptr_q];
  assign count_o     = count_q;

  a_no_write_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && !flush_i && !pop_i && count_q == 2'd2));

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues ROM reads under a two-credit limit,
// buffers returning instructions with their PCs and handles redirects.
// Handshake: an instruction transfers on any cycle where instr_valid_o and
// instr_ready_i are both high; valid never depends on ready.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               halt_i,
  input  logic               redirect_i,
  input  logic [31:0]        redirect_pc_i,
  output logic               rom_rden_o,
  output logic [31:0]        rom_pc_o,
  input  logic [INSTR_W-1:0] rom_instr_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [31:0]        instr_pc_o,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output fetch_state_e       state_o
);

  fetch_state_e       state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic               inflight_q, inflight_d;
  logic [31:0]        req_pc_q, req_pc_d;

  logic               req;
  logic               pop;
  logic               push;
  logic [2:0]         credit_used;
  logic [1:0]         fifo_count;
  logic [INSTR_W-1:0] head_data;
  logic [31:0]        head_pc;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inflight_d = 1'b0;
    req_pc_d   = req_pc_q;

    pop         = instr_valid_o & instr_ready_i;
    // Slots already spoken for once this cycle's pop is accounted for.
    credit_used = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};
    req         = !rst_i && (state_q == ST_RUN) && !redirect_i &&
                  (credit_used < 3'(FIFO_DEPTH));
    push        = inflight_q & ~redirect_i;

    case (state_q)
      ST_IDLE: if (!halt_i) state_d = ST_RUN;
      ST_RUN:  if (halt_i)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (redirect_i) begin
      pc_d = {redirect_pc_i[31:2], 2'b00};
    end else if (req) begin
      pc_d       = pc_q + 32'd4;
      inflight_d = 1'b1;
      req_pc_d   = pc_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      req_pc_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      req_pc_q   <= req_pc_d;
    end
  end

  fetch_fifo u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (redirect_i),
    .push_i      (push),
    .push_data_i (rom_instr_i),
    .push_pc_i   (req_pc_q),
    .pop_i       (pop),
    .head_data_o (head_data),
    .head_pc_o   (head_pc),
    .count_o     (fifo_count)
  );

  assign rom_rden_o    = req;
  assign rom_pc_o      = rst_i ? RESET_PC : pc_q;
  assign instr_valid_o = (fifo_count != 2'd0) && !rst_i;
  assign instr_o       = instr_valid_o ? head_data : '0;
  assign instr_pc_o    = instr_valid_o ? head_pc   : '0;
  assign state_o       = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, halt, redirect, ready;
  logic [31:0] redirect_pc;

  logic        rden_a, valid_a, rden_b, valid_b;
  logic [31:0] rom_pc_a, rom_q_a, instr_a, ipc_a;
  logic [31:0] rom_pc_b, rom_q_b, instr_b, ipc_b;
  fetch_state_e st_a, st_b;

  fetch_ctrl u_dut_a (
    .clk_i(clk), .rst_i(rst), .halt_i(halt), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .rom_rden_o(rden_a), .rom_pc_o(rom_pc_a),
    .rom_instr_i(rom_q_a), .instr_o(instr_a), .instr_pc_o(ipc_a),
    .instr_valid_o(valid_a), .instr_ready_i(ready), .state_o(st_a)
  );

  fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .halt_i(halt), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .rom_rden_o(rden_b), .rom_pc_o(rom_pc_b),
    .rom_instr_i(rom_q_b), .instr_o(instr_b), .instr_pc_o(ipc_b),
    .instr_valid_o(valid_b), .instr_ready_i(ready), .state_o(st_b)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0013;
  endfunction

  // ROM with a one-cycle registered read.
  always @(posedge clk) begin
    if (rden_a) rom_q_a <= rom_word(rom_pc_a);
    if (rden_b) rom_q_b <= rom_word(rom_pc_b);
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  // Reference model state: what the fetch unit must hold after each edge.
  logic        m_run    = 1'b0;
  logic [31:0] m_pc     = 32'h0;
  logic [31:0] m_buf[$];
  logic        m_inf    = 1'b0;
  logic [31:0] m_inf_pc = 32'h0;

  logic [31:0] req_log[$], req_b_log[$], deliv_log[$], req_cyc[$], deliv_cyc[$];

  always @(negedge clk) begin
    logic e_valid, e_pop, e_req;
    int   used;
    if (rst) begin
      check_bit("rst_rden", rden_a, 1'b0);
      check("rst_rom_pc", rom_pc_a, 32'h0);
      check_bit("rst_valid", valid_a, 1'b0);
      check("rst_instr", instr_a, 32'h0);
      check("rst_ipc", ipc_a, 32'h0);
      check("rst_rom_pc_b", rom_pc_b, 32'hFFFF_FFF8);
      m_run = 1'b0;
      m_pc  = 32'h0;
      m_buf.delete();
      m_inf = 1'b0;
    end else begin
      e_valid = (m_buf.size() != 0);
      e_pop   = e_valid && ready;
      used    = m_buf.size() + int'(m_inf) - int'(e_pop);
      e_req   = m_run && !redirect && (used < 2);

      check_bit("rden", rden_a, e_req);
      check("rom_pc", rom_pc_a, m_pc);
      check_bit("valid", valid_a, e_valid);
      check_bit("state_run", st_a == ST_RUN, m_run);
      if (e_valid) begin
        check("instr_pc", ipc_a, m_buf[0]);
        check("instr", instr_a, rom_word(m_buf[0]));
      end

      if (rden_a) begin
        req_log.push_back(rom_pc_a);
        req_cyc.push_back(32'(cyc));
      end
      if (valid_a && ready) begin
        deliv_log.push_back(ipc_a);
        deliv_cyc.push_back(32'(cyc));
      end
      if (rden_b) req_b_log.push_back(rom_pc_b);

      if (redirect) begin
        m_buf.delete();
        m_pc  = {redirect_pc[31:2], 2'b00};
        m_inf = 1'b0;
      end else begin
        if (e_pop) void'(m_buf.pop_front());
        if (m_inf) m_buf.push_back(m_inf_pc);
        m_inf = e_req;
        if (e_req) begin
          m_inf_pc = m_pc;
          m_pc     = m_pc + 32'd4;
        end
      end
      m_run = !halt;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    req_log.delete();
    req_b_log.delete();
    deliv_log.delete();
    req_cyc.delete();
    deliv_cyc.delete();
  endtask

  task automatic enter_reset();
    rst      = 1'b1;
    redirect = 1'b0;
    tick(2);
  endtask

  initial begin
    int n_before;
    rst = 1'b1; halt = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; ready = 1'b1;
    tick(2);

    // Streaming from reset with the consumer always ready.
    clear_logs();
    rst = 1'b0;
    tick(8);
    check("s1_req0", q_at(req_log, 0), 32'h0);
    check("s1_req1", q_at(req_log, 1), 32'h4);
    check("s1_req2", q_at(req_log, 2), 32'h8);
    check("s1_back_to_back", q_at(req_cyc, 1) - q_at(req_cyc, 0), 32'd1);
    check("s1_latency", q_at(deliv_cyc, 0) - q_at(req_cyc, 0), 32'd2);
    check("s1_first_pc", q_at(deliv_log, 0), 32'h0);
    check("s1b_req0", q_at(req_b_log, 0), 32'hFFFF_FFF8);
    check("s1b_req1", q_at(req_b_log, 1), 32'hFFFF_FFFC);
    check("s1b_req2", q_at(req_b_log, 2), 32'h0000_0000);

    // Backpressure: consumer stalled, then released.
    enter_reset();
    ready = 1'b0;
    clear_logs();
    rst = 1'b0;
    tick(8);
    check("s2_nreq", 32'(req_log.size()), 32'd2);
    check_bit("s2_valid", valid_a, 1'b1);
    check("s2_head_pc", ipc_a, 32'h0);
    ready = 1'b1;
    tick(8);
    for (int i = 0; i < 6; i++) check("s2_order", q_at(deliv_log, i), 32'(4 * i));

    // Redirect with a response in flight.
    enter_reset();
    ready = 1'b1;
    rst = 1'b0;
    tick(6);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick(1);
    redirect = 1'b0;
    clear_logs();
    tick(6);
    check("s3_req0", q_at(req_log, 0), 32'h100);
    check("s3_deliv0", q_at(deliv_log, 0), 32'h100);
    check("s3_deliv1", q_at(deliv_log, 1), 32'h104);

    // Halt and resume.
    enter_reset();
    clear_logs();
    rst = 1'b0;
    tick(5);
    halt = 1'b1;
    tick(1);
    n_before = req_log.size();
    tick(5);
    check("s4_halt_noreq", 32'(req_log.size()), 32'(n_before));
    check("s4_drained", 32'(deliv_log.size()), 32'(req_log.size()));
    halt = 1'b0;
    tick(6);
    check_bit("s4_resumed", req_log.size() > n_before, 1'b1);
    for (int i = 0; i < req_log.size(); i++) check("s4_req_seq", req_log[i], 32'(4 * i));
    for (int i = 0; i < deliv_log.size(); i++) check("s4_deliv_seq", deliv_log[i], 32'(4 * i));

    // Reset with one buffered entry and one response in flight.
    enter_reset();
    ready = 1'b0;
    rst = 1'b0;
    tick(3);
    check_bit("s5_pre_valid", valid_a, 1'b1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    clear_logs();
    #1;
    check_bit("s5_post_valid", valid_a, 1'b0);
    check("s5_post_rom_pc", rom_pc_a, 32'h0);
    ready = 1'b1;
    tick(8);
    check("s5_refetch", q_at(req_log, 0), 32'h0);
    check("s5_deliv0", q_at(deliv_log, 0), 32'h0);
    check("s5_deliv1", q_at(deliv_log, 1), 32'h4);

    // Redirect while idle, then start running.
    rst = 1'b1; halt = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick(1);
    redirect = 1'b0;
    clear_logs();
    tick(2);
    check("s6_idle_noreq", 32'(req_log.size()), 32'd0);
    halt = 1'b0;
    tick(6);
    check("s6_req0", q_at(req_log, 0), 32'h200);
    check("s6_deliv0", q_at(deliv_log, 0), 32'h200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
